dm_dmi_arbiter: RTL and testbench

//  Shares the single DMI slave port of DM_top between two DMI masters: port 0 = JTAG DTM,

---
 rtl/dm_dmi_arbiter.sv | 137 +++++++++++++
 tb/tb_dm_dmi_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dm_dmi_arbiter.sv
// rtl/dm_dmi_arbiter.sv - two-master DMI arbiter in front of DM_top
// Round-robin request grant, in-order response return via an owner-tag FIFO.
module dm_dmi_arbiter #(
    parameter int MaxOutstanding = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [1:0][40:0] req_i,
    output logic [1:0]       resp_valid_o,
    input  logic [1:0]       resp_ready_i,
    output logic [33:0]      resp_o,
    input  logic             lock0_i,
    output logic             dm_req_valid_o,
    input  logic             dm_req_ready_i,
    output logic [40:0]      dm_req_o,
    input  logic             dm_resp_valid_i,
    output logic             dm_resp_ready_o,
    input  logic [33:0]      dm_resp_i,
    output logic             owner_o,
    output logic             spurious_o
);

    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    logic [MaxOutstanding-1:0] tag_q;
    logic [PtrW-1:0]           wr_ptr_q;
    logic [PtrW-1:0]           rd_ptr_q;
    logic [CntW-1:0]           count_q;
    logic                      rr_q;
    logic                      hold_valid_q;
    logic                      hold_port_q;
    logic                      owner_q;
    logic                      spurious_q;

    logic       tag_full;
    logic       tag_empty;
    logic       head;
    logic [1:0] eligible;
    logic       any_grant;
    logic       grant_port;
    logic       push;
    logic       pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    // Full is taken from the registered count so a response pop never feeds the request path.
    assign tag_full  = (count_q == CntW'(MaxOutstanding));
    assign tag_empty = (count_q == '0);
    assign head      = tag_q[rd_ptr_q];

    always_comb begin
        eligible   = req_valid_i & {~lock0_i, 1'b1};
        any_grant  = 1'b0;
        grant_port = 1'b0;
        // A presented but unaccepted request keeps its grant, ignoring rr and lock.
        if (hold_valid_q) begin
            any_grant  = req_valid_i[hold_port_q];
            grant_port = hold_port_q;
        end else if (&eligible) begin
            any_grant  = 1'b1;
            grant_port = rr_q;
        end else if (eligible[0]) begin
            any_grant  = 1'b1;
            grant_port = 1'b0;
        end else if (eligible[1]) begin
            any_grant  = 1'b1;
            grant_port = 1'b1;
        end
    end

    always_comb begin
        dm_req_valid_o  = 1'b0;
        dm_req_o        = '0;
        req_ready_o     = 2'b00;
        resp_valid_o    = 2'b00;
        dm_resp_ready_o = 1'b0;
        if (!rst_i) begin
            dm_req_valid_o = any_grant & ~tag_full;
            if (any_grant) begin
                dm_req_o                = req_i[grant_port];
                req_ready_o[grant_port] = dm_req_ready_i & ~tag_full;
            end
            if (tag_empty) begin
                dm_resp_ready_o = 1'b1;
            end else begin
                resp_valid_o[head] = dm_resp_valid_i;
                dm_resp_ready_o    = resp_ready_i[head];
            end
        end
    end

    assign resp_o     = dm_resp_i;
    assign owner_o    = owner_q;
    assign spurious_o = spurious_q;
    assign push       = dm_req_valid_o & dm_req_ready_i;
    assign pop        = ~tag_empty & dm_resp_valid_i & dm_resp_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rr_q         <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_port_q  <= 1'b0;
            owner_q      <= 1'b0;
            spurious_q   <= 1'b0;
        end else begin
            if (push) begin
                tag_q[wr_ptr_q] <= grant_port;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
                rr_q            <= ~grant_port;
                owner_q         <= grant_port;
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            hold_valid_q <= dm_req_valid_o & ~dm_req_ready_i;
            hold_port_q  <= grant_port;
            if (tag_empty && dm_resp_valid_i) begin
                spurious_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dm_dmi_arbiter.sv
// tb/tb_dm_dmi_arbiter.sv - directed self-checking bench for dm_dmi_arbiter
module tb_dm_dmi_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][40:0] req;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic [33:0]      resp;
    logic             lock0;
    logic             dm_req_valid;
    logic             dm_req_ready;
    logic [40:0]      dm_req;
    logic             dm_resp_valid;
    logic             dm_resp_ready;
    logic [33:0]      dm_resp;
    logic             owner;
    logic             spurious;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dm_dmi_arbiter #(.MaxOutstanding(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_i(req),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_o(resp),
        .lock0_i(lock0),
        .dm_req_valid_o(dm_req_valid), .dm_req_ready_i(dm_req_ready), .dm_req_o(dm_req),
        .dm_resp_valid_i(dm_resp_valid), .dm_resp_ready_o(dm_resp_ready), .dm_resp_i(dm_resp),
        .owner_o(owner), .spurious_o(spurious)
    );

    function automatic logic [40:0] mk(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d);
        return {a, op, d};
    endfunction

    task automatic test_reset;
        rst = 1'b1; req_valid = 2'b11; resp_ready = 2'b11; lock0 = 1'b0;
        dm_req_ready = 1'b1; dm_resp_valid = 1'b1; dm_resp = 34'h3_0000_0001;
        req[0] = mk(7'h11, 2'd1, 32'h0); req[1] = mk(7'h22, 2'd1, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready got %b exp 00", req_ready); end
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL rst_resp_valid got %b exp 00", resp_valid); end
        checks++; if (dm_req_valid !== 1'b0) begin errors++; $display("FAIL rst_dm_req_valid got %b exp 0", dm_req_valid); end
        checks++; if (dm_resp_ready !== 1'b0) begin errors++; $display("FAIL rst_dm_resp_ready got %b exp 0", dm_resp_ready); end
        checks++; if (dm_req !== 41'h0) begin errors++; $display("FAIL rst_dm_req got %h exp 0", dm_req); end
        checks++; if (owner !== 1'b0) begin errors++; $display("FAIL rst_owner got %b exp 0", owner); end
        checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL rst_spurious got %b exp 0", spurious); end
        rst = 1'b0; req_valid = 2'b00; resp_ready = 2'b00; dm_req_ready = 1'b0; dm_resp_valid = 1'b0;
    endtask

    task automatic test_alternate;
        logic gp;
        logic rp;
        req[0] = mk(7'h11, 2'd1, 32'h0);
        req[1] = mk(7'h22, 2'd1, 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req_valid = (k < 4) ? 2'b11 : 2'b00;
            dm_req_ready = 1'b1; resp_ready = 2'b11;
            dm_resp_valid = (k > 0);
            dm_resp = {32'(32'hD000_0000 + k), 2'b00};
            #1;
            gp = (k == 1 || k == 3);
            rp = (k == 2 || k == 4);
            if (k < 4) begin
                checks++; if (dm_req !== (gp ? mk(7'h22, 2'd1, 32'h0) : mk(7'h11, 2'd1, 32'h0))) begin errors++; $display("FAIL alt_dm_req k=%0d got %h", k, dm_req); end
                checks++; if (req_ready !== (gp ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_req_ready k=%0d got %b exp %b", k, req_ready, gp ? 2'b10 : 2'b01); end
            end
            if (k > 0) begin
                checks++; if (resp_valid !== (rp ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_resp_valid k=%0d got %b exp %b", k, resp_valid, rp ? 2'b10 : 2'b01); end
                checks++; if (resp !== {32'(32'hD000_0000 + k), 2'b00}) begin errors++; $display("FAIL alt_resp_data k=%0d got %h", k, resp); end
                checks++; if (owner !== rp) begin errors++; $display("FAIL alt_owner k=%0d got %b exp %b", k, owner, rp); end
            end
        end
        @(negedge clk);
        dm_resp_valid = 1'b0; dm_req_ready = 1'b0; #1;
        checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL alt_spurious got %b exp 0", spurious); end
    endtask

    task automatic test_full;
        @(negedge clk);
        req_valid = 2'b01; dm_req_ready = 1'b1; resp_ready = 2'b01; dm_resp_valid = 1'b0; #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL full_acc1 got %b exp 01", req_ready); end
        @(negedge clk); #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL full_acc2 got %b exp 01", req_ready); end
        @(negedge clk); #1;
        checks++; if (req_ready !== 2'b00 || dm_req_valid !== 1'b0) begin errors++; $display("FAIL full_block got %b/%b exp 00/0", req_ready, dm_req_valid); end
        dm_resp_valid = 1'b1; #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL full_pop_same got %b exp 00", req_ready); end
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL full_resp_valid got %b exp 01", resp_valid); end
        @(negedge clk);
        dm_resp_valid = 1'b0; #1;
        checks++; if (req_ready !== 2'b01 || dm_req_valid !== 1'b1) begin errors++; $display("FAIL full_pop_next got %b/%b exp 01/1", req_ready, dm_req_valid); end
        @(negedge clk);
        req_valid = 2'b00; dm_req_ready = 1'b0; dm_resp_valid = 1'b1; #1;
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL full_drain1 got %b exp 01", resp_valid); end
        @(negedge clk); #1;
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL full_drain2 got %b exp 01", resp_valid); end
        @(negedge clk);
        dm_resp_valid = 1'b0; #1;
        checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL full_spurious got %b exp 0", spurious); end
    endtask

    task automatic test_lock;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            lock0 = (k < 4);
            req_valid = (k < 5) ? 2'b11 : 2'b00;
            dm_req_ready = 1'b1; resp_ready = 2'b11;
            dm_resp_valid = (k > 0);
            #1;
            if (k < 5) begin
                checks++; if (req_ready !== ((k == 4) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL lock_grant k=%0d got %b exp %b", k, req_ready, (k == 4) ? 2'b10 : 2'b01); end
            end
            if (k > 0) begin
                checks++; if (resp_valid !== ((k == 5) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL lock_resp k=%0d got %b exp %b", k, resp_valid, (k == 5) ? 2'b10 : 2'b01); end
            end
        end
        checks++; if (owner !== 1'b1) begin errors++; $display("FAIL lock_owner got %b exp 1", owner); end
        @(negedge clk);
        dm_resp_valid = 1'b0; dm_req_ready = 1'b0; lock0 = 1'b0;
    endtask

    task automatic test_hold;
        req[0] = mk(7'h44, 2'd2, 32'h0000_CAFE);
        req[1] = mk(7'h33, 2'd2, 32'h1234_5678);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = (k == 0) ? 2'b10 : 2'b11;
            lock0 = (k == 2);
            dm_req_ready = 1'b0; #1;
            checks++; if (dm_req !== mk(7'h33, 2'd2, 32'h1234_5678) || dm_req_valid !== 1'b1) begin errors++; $display("FAIL hold_payload k=%0d got %h/%b", k, dm_req, dm_req_valid); end
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL hold_ready k=%0d got %b exp 00", k, req_ready); end
        end
        @(negedge clk);
        lock0 = 1'b0; dm_req_ready = 1'b1; #1;
        checks++; if (dm_req !== mk(7'h33, 2'd2, 32'h1234_5678) || req_ready !== 2'b10) begin errors++; $display("FAIL hold_accept got %h/%b", dm_req, req_ready); end
        @(negedge clk);
        req_valid = 2'b01; #1;
        checks++; if (dm_req !== mk(7'h44, 2'd2, 32'h0000_CAFE) || req_ready !== 2'b01) begin errors++; $display("FAIL hold_release got %h/%b", dm_req, req_ready); end
        @(negedge clk);
        req_valid = 2'b00; dm_req_ready = 1'b0; dm_resp_valid = 1'b1; resp_ready = 2'b11; #1;
        checks++; if (resp_valid !== 2'b10) begin errors++; $display("FAIL hold_resp1 got %b exp 10", resp_valid); end
        checks++; if (owner !== 1'b0) begin errors++; $display("FAIL hold_owner got %b exp 0", owner); end
        @(negedge clk); #1;
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL hold_resp2 got %b exp 01", resp_valid); end
        @(negedge clk);
        dm_resp_valid = 1'b0; #1;
        checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL hold_spurious got %b exp 0", spurious); end
    endtask

    task automatic test_spurious;
        @(negedge clk);
        dm_resp_valid = 1'b1; resp_ready = 2'b00; #1;
        checks++; if (dm_resp_ready !== 1'b1) begin errors++; $display("FAIL spur_drain got %b exp 1", dm_resp_ready); end
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL spur_resp_valid got %b exp 00", resp_valid); end
        checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL spur_early got %b exp 0", spurious); end
        @(negedge clk);
        dm_resp_valid = 1'b0; #1;
        checks++; if (spurious !== 1'b1) begin errors++; $display("FAIL spur_set got %b exp 1", spurious); end
        @(negedge clk); #1;
        checks++; if (spurious !== 1'b1) begin errors++; $display("FAIL spur_sticky got %b exp 1", spurious); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; #1;
        checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL spur_clear got %b exp 0", spurious); end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_full();
        test_lock();
        test_hold();
        test_spurious();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
